// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: state encoding,
// requester count, select width and the round-robin search helper.
package mux4_arb_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // Searches last+1, last+2, ... wrapping 3->0. With excl_owner set, the
    // current owner (always equal to last) is skipped, so only others win.
    function automatic rr_pick_t rr_next(
        input logic [NREQ-1:0]  req,
        input logic [SEL_W-1:0] last,
        input logic             excl_owner
    );
        rr_pick_t         pick;
        logic [SEL_W-1:0] idx;
        pick = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = last + SEL_W'(i);
            if (!pick.valid && req[idx] && !(excl_owner && (idx == last))) begin
                pick.valid = 1'b1;
                pick.idx   = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] idx_onehot(input logic [SEL_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_sel.sv
// DW-wide 4:1 multiplexer with enable; output forced to zero while disabled.
module mux4_sel
    import mux4_arb_pkg::*;
#(
    parameter int DW = 2
) (
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [DW-1:0]    c,
    input  logic [DW-1:0]    d,
    input  logic [SEL_W-1:0] s,
    input  logic             en,
    output logic [DW-1:0]    y
);

    always_comb begin
        y = '0;
        if (en) begin
            case (s)
                2'd0:    y = a;
                2'd1:    y = b;
                2'd2:    y = c;
                default: y = d;
            endcase
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select/enable of a shared 4:1 mux.
// Optional grant hold limit enabled by defining MUX4_ARB_HOLD_LIMIT_EN.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int DW       = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NREQ-1:0]  REQ,
    input  logic [DW-1:0]    A,
    input  logic [DW-1:0]    B,
    input  logic [DW-1:0]    C,
    input  logic [DW-1:0]    D,
    output logic [NREQ-1:0]  GNT,
    output logic [SEL_W-1:0] S,
    output logic             EN,
    output logic [DW-1:0]    Y
);

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be >= 1");
    end

    arb_state_t       state_reg;
    logic [NREQ-1:0]  gnt_reg;
    logic [SEL_W-1:0] s_reg;
    logic             en_reg;
    logic [SEL_W-1:0] last_reg;
    rr_pick_t         pick_any;
    rr_pick_t         pick_other;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_reg;
`endif

    // pick_any serves the idle search; pick_other finds a successor to the owner.
    always_comb begin
        pick_any   = rr_next(REQ, last_reg, 1'b0);
        pick_other = rr_next(REQ, last_reg, 1'b1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            s_reg     <= '0;
            en_reg    <= 1'b0;
            last_reg  <= SEL_W'(NREQ - 1);
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            hold_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_any.valid) begin
                        state_reg <= ST_GRANT;
                        gnt_reg   <= idx_onehot(pick_any.idx);
                        s_reg     <= pick_any.idx;
                        en_reg    <= 1'b1;
                        last_reg  <= pick_any.idx;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                        hold_reg  <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    if (REQ[s_reg]) begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                        // Saturated owner yields only when someone else is waiting.
                        if ((hold_reg == HOLD_SAT) && pick_other.valid) begin
                            gnt_reg  <= idx_onehot(pick_other.idx);
                            s_reg    <= pick_other.idx;
                            last_reg <= pick_other.idx;
                            hold_reg <= '0;
                        end else if (hold_reg != HOLD_SAT) begin
                            hold_reg <= hold_reg + 1'b1;
                        end
`endif
                    end else if (pick_other.valid) begin
                        gnt_reg  <= idx_onehot(pick_other.idx);
                        s_reg    <= pick_other.idx;
                        last_reg <= pick_other.idx;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                        hold_reg <= '0;
`endif
                    end else begin
                        // S keeps its last value so the pointer history stays visible.
                        state_reg <= ST_IDLE;
                        gnt_reg   <= '0;
                        en_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    gnt_reg   <= '0;
                    en_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign GNT = gnt_reg;
    assign S   = s_reg;
    assign EN  = en_reg;

    mux4_sel #(
        .DW (DW)
    ) u_sel (
        .a  (A),
        .b  (B),
        .c  (C),
        .d  (D),
        .s  (s_reg),
        .en (en_reg),
        .y  (Y)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized bench for mux4_rr_arbiter against a behavioural
// round-robin model; hold-limit expectations follow MUX4_ARB_HOLD_LIMIT_EN.
module tb_mux4_rr_arbiter;

    localparam int DW       = 2;
    localparam int MAX_HOLD = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [3:0]    REQ = 4'b0000;
    logic [DW-1:0] A = '0, B = '0, C = '0, D = '0;
    logic [3:0]    GNT;
    logic [1:0]    S;
    logic          EN;
    logic [DW-1:0] Y;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: owner index or -1 when idle.
    int m_owner = -1;
    int m_last  = 3;
    int m_hold  = 0;
    int m_sel   = 0;

    mux4_rr_arbiter #(
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .REQ (REQ),
        .A   (A),
        .B   (B),
        .C   (C),
        .D   (D),
        .GNT (GNT),
        .S   (S),
        .EN  (EN),
        .Y   (Y)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // First requester after 'last' in wrap-around order, skipping 'excl'.
    function automatic int first_req(input logic [3:0] req, input int last, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (idx != excl && req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int other;
        if (RST) begin
            m_owner = -1; m_last = 3; m_hold = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            other = first_req(REQ, m_last, -1);
            if (other >= 0) begin
                m_owner = other; m_last = other; m_sel = other; m_hold = 0;
            end
        end else begin
            other = first_req(REQ, m_owner, m_owner);
            if (REQ[m_owner]) begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
                if (m_hold == MAX_HOLD - 1 && other >= 0) begin
                    m_owner = other; m_last = other; m_sel = other; m_hold = 0;
                end else if (m_hold < MAX_HOLD - 1) begin
                    m_hold++;
                end
`endif
            end else if (other >= 0) begin
                m_owner = other; m_last = other; m_sel = other; m_hold = 0;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    task automatic model_check();
        logic [3:0]    e_gnt;
        logic [DW-1:0] e_y;
        logic [DW-1:0] src [4];
        src[0] = A; src[1] = B; src[2] = C; src[3] = D;
        e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        e_y   = (m_owner < 0) ? '0 : src[m_sel];
        chk("gnt", 8'(GNT), 8'(e_gnt));
        chk("s",   8'(S),   8'(m_sel));
        chk("en",  8'(EN),  8'(m_owner >= 0));
        chk("y",   8'(Y),   8'(e_y));
    endtask

    // One clock: drive at negedge, model the posedge, sample 1 time unit later.
    task automatic step(input logic rst, input logic [3:0] req);
        @(negedge CLK);
        RST = rst;
        REQ = req;
        @(posedge CLK);
        model_edge();
        #1;
        cyc++;
        $display("cyc %0d rst=%0b req=%b a=%0d b=%0d c=%0d d=%0d -> gnt=%b s=%0d en=%0b y=%0d",
                 cyc, rst, req, A, B, C, D, GNT, S, EN, Y);
        model_check();
    endtask

    initial begin
        A = 2'b00; B = 2'b01; C = 2'b10; D = 2'b11;

        // Reset with all requests asserted, then first grant goes to A.
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        chk("rst_gnt", 8'(GNT), 8'h00);
        chk("rst_en",  8'(EN),  8'h00);
        chk("rst_y",   8'(Y),   8'h00);
        step(1'b0, 4'b1111);
        chk("first_gnt", 8'(GNT), 8'h01);

        // Single request from C, then release to idle.
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0100);
        chk("c_gnt", 8'(GNT), 8'h04);
        chk("c_s",   8'(S),   8'h02);
        chk("c_y",   8'(Y),   8'h02);
        step(1'b0, 4'b0000);
        chk("idle_en", 8'(EN), 8'h00);
        chk("idle_y",  8'(Y),  8'h00);

        // Each owner drops its request once granted: 0,1,2,3,0 back to back.
        step(1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            logic [3:0] r;
            r = (i == 0) ? 4'b1111 : (4'b1111 & ~GNT);
            step(1'b0, r);
            chk("rr_gnt", 8'(GNT), 8'(4'b0001 << (i % 4)));
            chk("rr_en",  8'(EN),  8'h01);
        end

        // Owner B releases while D waits: direct handover.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        chk("b_gnt", 8'(GNT), 8'h02);
        step(1'b0, 4'b1000);
        chk("hand_s",  8'(S),  8'h03);
        chk("hand_y",  8'(Y),  8'h03);
        chk("hand_en", 8'(EN), 8'h01);

        // A and B held continuously: hold limit decides alternation.
        step(1'b1, 4'b0000);
        for (int i = 0; i < 12; i++) begin
            logic [3:0] e;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
            e = ((i / 4) % 2 == 1) ? 4'b0010 : 4'b0001;
`else
            e = 4'b0001;
`endif
            step(1'b0, 4'b0011);
            chk("hold_gnt", 8'(GNT), 8'(e));
        end

        // Reset in the middle of a grant to D.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b1000);
        step(1'b0, 4'b1001);
        chk("pre_rst_gnt", 8'(GNT), 8'h08);
        step(1'b1, 4'b1001);
        chk("mid_rst_gnt", 8'(GNT), 8'h00);
        chk("mid_rst_en",  8'(EN),  8'h00);
        step(1'b0, 4'b1001);
        chk("post_rst_gnt", 8'(GNT), 8'h01);

        // Randomized traffic with occasional resets and changing data.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            A = DW'($urandom); B = DW'($urandom); C = DW'($urandom); D = DW'($urandom);
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 4'($urandom);
            step(($urandom_range(0, 59) == 0), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
